// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave like-SRAM arbiter with in-order response routing.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin between masters under contention (default: data wins).
//
// state         | meaning
// ST_FREE       | no pending unaccepted request; arbitrate freely
// ST_LOCK_INST  | inst request presented but not accepted; hold sel=inst while inst_req stays high
// ST_LOCK_DATA  | data request presented but not accepted; hold sel=data while data_req stays high
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  outstanding,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } lock_state_t;

    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic [3:0]  r_fifo;     // one requester ID per slot, 0=inst 1=data
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        r_err;
`ifdef ARB_ROUND_ROBIN_EN
    logic        r_rr;
`endif

    logic w_full;
    logic w_lock_hold;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full      = (r_count == MAX_CNT);
    assign w_lock_hold = ((r_state == ST_LOCK_INST) & inst_req) |
                         ((r_state == ST_LOCK_DATA) & data_req);
    assign mem_req     = (inst_req | data_req) & ~w_full;

    always_comb begin
        w_sel = data_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req & data_req) w_sel = r_rr;
`endif
        if (w_lock_hold) w_sel = (r_state == ST_LOCK_DATA);
    end

    // A dropped locked request falls through to ST_FREE and re-arbitrates above.
    always_comb begin
        w_state_nxt = ST_FREE;
        if (mem_req & ~mem_addr_ok) w_state_nxt = w_sel ? ST_LOCK_DATA : ST_LOCK_INST;
    end

    assign mem_wr    = w_sel ? data_wr    : inst_wr;
    assign mem_size  = w_sel ? data_size  : inst_size;
    assign mem_wstrb = w_sel ? data_wstrb : inst_wstrb;
    assign mem_addr  = w_sel ? data_addr  : inst_addr;
    assign mem_wdata = w_sel ? data_wdata : inst_wdata;

    assign w_push       = mem_req & mem_addr_ok;
    assign w_pop        = mem_data_ok & (r_count != 3'd0);
    assign w_head       = r_fifo[r_rptr];
    assign inst_addr_ok = w_push & ~w_sel;
    assign data_addr_ok = w_push & w_sel;
    assign inst_data_ok = w_pop & ~w_head;
    assign data_data_ok = w_pop & w_head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign outstanding  = r_count;
    assign arb_err      = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FREE;
            r_fifo  <= 4'd0;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= (r_wptr == LAST_PTR) ? 2'd0 : r_wptr + 2'd1;
            end
            if (w_pop) r_rptr <= (r_rptr == LAST_PTR) ? 2'd0 : r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (mem_data_ok & (r_count == 3'd0)) r_err <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            if (w_push & (w_sel == r_rr)) r_rr <= ~r_rr;
`endif
        end
    end

endmodule
